clint_mtimer: RTL and testbench



---
 rtl/clint_mtimer.sv | 194 +++++++++++++++++++
 tb/tb_clint_mtimer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_mtimer.sv
// Core-local timer and software-interrupt unit behind a req/gnt register port.
// Shared 64-bit mtime (RTC or clk tick, prescaled) and per-hart mtimecmp/msip.
module clint_mtimer #(
    parameter int NR_HARTS    = 1,
    parameter int DATA_WIDTH  = 64,
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE_W  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [15:0]             addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    input  logic                    rtc_i,
    output logic [NR_HARTS-1:0]     timer_irq_o,
    output logic [NR_HARTS-1:0]     ipi_o
);
    localparam logic [11:0] NH12 = 12'(NR_HARTS);

    function automatic logic [63:0] merge_be(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  be);
        logic [63:0] res;
        res = old_v;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
            else       res[8*b +: 8] = old_v[8*b +: 8];
        end
        return res;
    endfunction

    logic [63:0]            mtime_r;
    logic [63:0]            mtimecmp_r [NR_HARTS];
    logic [NR_HARTS-1:0]    msip_r;
    logic                   en_r;
    logic                   src_r;
    logic [PRESCALE_W-1:0]  prescale_r;
    logic [PRESCALE_W-1:0]  pcnt_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rtc_prev_r;
    logic [NR_HARTS-1:0]    timer_irq_r;
    logic                   rvalid_r;
    logic                   err_r;
    logic [DATA_WIDTH-1:0]  rdata_r;

    logic [63:0]           wdata64_s;
    logic [7:0]            be8_s;
    logic [63:0]           rd64_s;
    logic [63:0]           ctrl64_s;
    logic [63:0]           ctrl_new_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [11:0]           msip_idx_s;
    logic [10:0]           cmp_idx_s;
    logic [2:0]            lane_byte_s;
    logic [5:0]            lane_bit_s;
    logic                  hi_bad_s;
    logic                  aligned_s;
    logic                  msip_hit_s;
    logic                  cmp_hit_s;
    logic                  ctrl_hit_s;
    logic                  mtime_hit_s;
    logic                  err_s;
    logic                  wr_s;
    logic                  rtc_rise_s;
    logic                  tick_s;
    logic                  inc_s;

    // Every register is viewed as 64 bits; a 32-bit port maps onto one half via addr_i[2].
    generate
        if (DATA_WIDTH == 32) begin : g_dw32
            assign wdata64_s = addr_i[2] ? {wdata_i, 32'd0} : {32'd0, wdata_i};
            assign be8_s     = addr_i[2] ? {be_i, 4'd0} : {4'd0, be_i};
            assign rd_word_s = addr_i[2] ? rd64_s[63:32] : rd64_s[31:0];
            assign hi_bad_s  = 1'b0;
        end else begin : g_dw64
            assign wdata64_s = wdata_i;
            assign be8_s     = be_i;
            assign rd_word_s = rd64_s;
            assign hi_bad_s  = addr_i[2];
        end
    endgenerate

    assign msip_idx_s  = addr_i[13:2];
    assign cmp_idx_s   = addr_i[13:3];
    assign lane_byte_s = {addr_i[2], 2'b00};
    assign lane_bit_s  = {addr_i[2], 5'b00000};

    // Address decode; MSIP is a 32-bit register so it may sit in either lane.
    always_comb begin
        aligned_s   = (addr_i[1:0] == 2'b00);
        msip_hit_s  = aligned_s && (addr_i[15:14] == 2'b00) && (msip_idx_s < NH12);
        cmp_hit_s   = aligned_s && !hi_bad_s && (addr_i[15:14] == 2'b01)
                      && ({1'b0, cmp_idx_s} < NH12);
        ctrl_hit_s  = aligned_s && !hi_bad_s && (addr_i[15:3] == 13'h17FE);
        mtime_hit_s = aligned_s && !hi_bad_s && (addr_i[15:3] == 13'h17FF);
        err_s       = !(msip_hit_s || cmp_hit_s || ctrl_hit_s || mtime_hit_s);
    end

    // CTRL as a 64-bit view with unimplemented bits reading zero.
    always_comb begin
        ctrl64_s                  = 64'd0;
        ctrl64_s[0]               = en_r;
        ctrl64_s[1]               = src_r;
        ctrl64_s[8 +: PRESCALE_W] = prescale_r;
    end

    assign ctrl_new_s = merge_be(ctrl64_s, wdata64_s, be8_s);

    // Read mux over the 64-bit register views.
    always_comb begin
        rd64_s = 64'd0;
        for (int h = 0; h < NR_HARTS; h++) begin
            rd64_s = rd64_s
                   | ({63'd0, msip_r[h] & msip_hit_s & (msip_idx_s == 12'(h))} << lane_bit_s)
                   | (mtimecmp_r[h] & {64{cmp_hit_s && (cmp_idx_s == 11'(h))}});
        end
        rd64_s = rd64_s | (ctrl64_s & {64{ctrl_hit_s}}) | (mtime_r & {64{mtime_hit_s}});
    end

    assign wr_s       = req_i & we_i & ~err_s;
    assign rtc_rise_s = sync_r[SYNC_STAGES-1] & ~rtc_prev_r;
    assign tick_s     = en_r & (src_r | rtc_rise_s);
    assign inc_s      = tick_s && (pcnt_r == prescale_r);

    // Timer state, per-hart registers and IRQ flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime_r     <= 64'd0;
            msip_r      <= {NR_HARTS{1'b0}};
            en_r        <= 1'b1;
            src_r       <= 1'b0;
            prescale_r  <= {PRESCALE_W{1'b0}};
            pcnt_r      <= {PRESCALE_W{1'b0}};
            sync_r      <= {SYNC_STAGES{1'b0}};
            rtc_prev_r  <= 1'b0;
            timer_irq_r <= {NR_HARTS{1'b0}};
            for (int h = 0; h < NR_HARTS; h++) begin
                mtimecmp_r[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end else begin
            sync_r     <= {sync_r[SYNC_STAGES-2:0], rtc_i};
            rtc_prev_r <= sync_r[SYNC_STAGES-1];
            // A bus write to MTIME overrides a coincident increment.
            if (wr_s && mtime_hit_s) begin
                mtime_r <= merge_be(mtime_r, wdata64_s, be8_s);
            end else if (inc_s) begin
                mtime_r <= mtime_r + 64'd1;
            end
            if (wr_s && ctrl_hit_s) begin
                en_r       <= ctrl_new_s[0];
                src_r      <= ctrl_new_s[1];
                prescale_r <= ctrl_new_s[8 +: PRESCALE_W];
                pcnt_r     <= {PRESCALE_W{1'b0}};
            end else if (tick_s) begin
                pcnt_r <= inc_s ? {PRESCALE_W{1'b0}} : pcnt_r + PRESCALE_W'(1);
            end
            for (int h = 0; h < NR_HARTS; h++) begin
                if (wr_s && msip_hit_s && (msip_idx_s == 12'(h)) && be8_s[lane_byte_s]) begin
                    msip_r[h] <= wdata64_s[lane_bit_s];
                end
                if (wr_s && cmp_hit_s && (cmp_idx_s == 11'(h))) begin
                    mtimecmp_r[h] <= merge_be(mtimecmp_r[h], wdata64_s, be8_s);
                end
                timer_irq_r[h] <= (mtime_r >= mtimecmp_r[h]);
            end
        end
    end

    // One-cycle response; reset discards any pending response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            rvalid_r <= req_i;
            err_r    <= req_i & err_s;
            rdata_r  <= (req_i && !we_i && !err_s) ? rd_word_s : {DATA_WIDTH{1'b0}};
        end
    end

    assign gnt_o       = req_i;
    assign rvalid_o    = rvalid_r;
    assign err_o       = err_r;
    assign rdata_o     = rdata_r;
    assign timer_irq_o = timer_irq_r;
    assign ipi_o       = msip_r;
endmodule

// File: tb/tb_clint_mtimer.sv
// Self-checking bench for clint_mtimer (4 harts, 32-bit port): vector table plus
// multi-cycle sequences, with bus responses checked through a scoreboard queue.
module tb_clint_mtimer;
    localparam int NH = 4;
    localparam int DW = 32;
    localparam int SS = 2;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_i;
    logic          we_i;
    logic [15:0]   addr_i;
    logic [DW-1:0] wdata_i;
    logic [3:0]    be_i;
    logic          gnt_o;
    logic          rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          err_o;
    logic          rtc_i;
    logic [NH-1:0] timer_irq_o;
    logic [NH-1:0] ipi_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    always #5 clk = ~clk;

    clint_mtimer #(
        .NR_HARTS(NH), .DATA_WIDTH(DW), .SYNC_STAGES(SS), .PRESCALE_W(PW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .rtc_i(rtc_i),
        .timer_irq_o(timer_irq_o), .ipi_o(ipi_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Response monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rvalid", {63'd0, rvalid_o}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("rdata@%h", e.addr), {32'd0, rdata_o}, {32'd0, e.rdata});
                check($sformatf("err@%h", e.addr), {63'd0, err_o}, {63'd0, e.err});
            end
        end
    end

    task automatic do_req(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
        e.addr = addr; e.rdata = exp_rdata; e.err = exp_err;
        sb_q.push_back(e);
        #1;
        check("gnt", {63'd0, gnt_o}, 64'd1);
        @(posedge clk); #1;
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, input logic [31:0] exp_rdata);
        do_req(1'b0, addr, 32'd0, 4'd0, exp_rdata, 1'b0);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        do_req(1'b1, addr, wdata, be, 32'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [23];
        int   exp_mt;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 16'd0;
        wdata_i = 32'd0; be_i = 4'd0; rtc_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid", {63'd0, rvalid_o}, 64'd0);
        check("rst_err", {63'd0, err_o}, 64'd0);
        check("rst_rdata", {32'd0, rdata_o}, 64'd0);
        check("rst_irq", {60'd0, timer_irq_o}, 64'd0);
        check("rst_ipi", {60'd0, ipi_o}, 64'd0);
        rst_i = 1'b0;
        idle(1);

        // we, addr, wdata, be, expected rdata, expected err
        tbl[0]  = '{1'b0, 16'hBFF8, 32'h0,          4'h0, 32'h0,          1'b0};
        tbl[1]  = '{1'b0, 16'hBFFC, 32'h0,          4'h0, 32'h0,          1'b0};
        tbl[2]  = '{1'b0, 16'h4000, 32'h0,          4'h0, 32'hFFFF_FFFF,  1'b0};
        tbl[3]  = '{1'b0, 16'h4004, 32'h0,          4'h0, 32'hFFFF_FFFF,  1'b0};
        tbl[4]  = '{1'b0, 16'hBFF0, 32'h0,          4'h0, 32'h1,          1'b0};
        tbl[5]  = '{1'b0, 16'hBFF4, 32'h0,          4'h0, 32'h0,          1'b0};
        tbl[6]  = '{1'b1, 16'h0004, 32'hFFFF_FFFF,  4'hF, 32'h0,          1'b0};
        tbl[7]  = '{1'b0, 16'h0004, 32'h0,          4'h0, 32'h1,          1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 32'h0,          4'h0, 32'h0,          1'b0};
        tbl[9]  = '{1'b1, 16'h4020, 32'h55,         4'hF, 32'h0,          1'b1};
        tbl[10] = '{1'b0, 16'h4020, 32'h0,          4'h0, 32'h0,          1'b1};
        tbl[11] = '{1'b0, 16'h0002, 32'h0,          4'h0, 32'h0,          1'b1};
        tbl[12] = '{1'b1, 16'h0002, 32'h1,          4'hF, 32'h0,          1'b1};
        tbl[13] = '{1'b0, 16'h8000, 32'h0,          4'h0, 32'h0,          1'b1};
        tbl[14] = '{1'b1, 16'h8000, 32'h1,          4'hF, 32'h0,          1'b1};
        tbl[15] = '{1'b0, 16'h0010, 32'h0,          4'h0, 32'h0,          1'b1};
        tbl[16] = '{1'b0, 16'h401C, 32'h0,          4'h0, 32'hFFFF_FFFF,  1'b0};
        tbl[17] = '{1'b1, 16'h4000, 32'h1234_5678,  4'h5, 32'h0,          1'b0};
        tbl[18] = '{1'b0, 16'h4000, 32'h0,          4'h0, 32'hFF34_FF78,  1'b0};
        tbl[19] = '{1'b0, 16'h0000, 32'h0,          4'h0, 32'h0,          1'b0};
        tbl[20] = '{1'b1, 16'hBFF0, 32'hFFFF_0301,  4'hF, 32'h0,          1'b0};
        tbl[21] = '{1'b0, 16'hBFF0, 32'h0,          4'h0, 32'h0000_0301,  1'b0};
        tbl[22] = '{1'b1, 16'hBFF0, 32'h1,          4'hF, 32'h0,          1'b0};
        for (int i = 0; i < 23; i++) begin
            do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].rdata, tbl[i].err);
        end
        idle(2);
        check("ipi_after_tbl", {60'd0, ipi_o}, 64'h2);
        check("irq_after_tbl", {60'd0, timer_irq_o}, 64'h0);

        // MSIP write reaches ipi_o one cycle after grant; be=0 keeps the bit
        wr(16'h000C, 32'h1, 4'hF);
        check("ipi_set3", {60'd0, ipi_o}, 64'hA);
        wr(16'h0004, 32'h0, 4'h0);
        check("ipi_be0", {60'd0, ipi_o}, 64'hA);
        wr(16'h0004, 32'h0, 4'hF);
        check("ipi_clr1", {60'd0, ipi_o}, 64'h8);

        // Write/tick collision with a tick every clk
        wr(16'hBFF0, 32'h3, 4'hF);
        wr(16'hBFF8, 32'h1234, 4'hF);
        rd(16'hBFF8, 32'h1234);
        rd(16'hBFF8, 32'h1235);
        wr(16'hBFF0, 32'h0, 4'hF);
        rd(16'hBFF8, 32'h1237);
        rd(16'hBFF8, 32'h1237);
        rd(16'hBFFC, 32'h0);

        // Prescaled timer IRQ: PRESCALE=3, MTIMECMP[2]=10
        wr(16'hBFF8, 32'h0, 4'hF);
        wr(16'h4010, 32'd10, 4'hF);
        wr(16'h4014, 32'h0, 4'hF);
        wr(16'hBFF0, 32'h303, 4'hF);
        for (int k = 0; k < 51; k++) begin
            check($sformatf("irq_presc_k%0d", k), {60'd0, timer_irq_o},
                  (k >= 41) ? 64'h4 : 64'h0);
            rd(16'hBFF8, 32'(k / 4));
        end
        check("irq_before_cmp100", {60'd0, timer_irq_o}, 64'h4);
        wr(16'h4010, 32'd100, 4'hF);
        check("irq_cmp100_1cyc", {60'd0, timer_irq_o}, 64'h4);
        idle(1);
        check("irq_cmp100_2cyc", {60'd0, timer_irq_o}, 64'h0);
        wr(16'hBFF0, 32'h0, 4'hF);

        // RTC path: 5 periods of 8 clk, increment SS+1 cycles after each rise
        wr(16'hBFF8, 32'h0, 4'hF);
        wr(16'hBFF0, 32'h1, 4'hF);
        for (int k = 0; k < 46; k++) begin
            rtc_i = (k < 40) && ((k % 8) < 4);
            exp_mt = 0;
            for (int p = 0; p < 5; p++) begin
                if (8 * p + SS + 1 <= k) exp_mt++;
            end
            rd(16'hBFF8, 32'(exp_mt));
        end
        wr(16'hBFF0, 32'h0, 4'hF);
        for (int k = 0; k < 20; k++) begin
            rtc_i = ((k % 8) < 4);
            rd(16'hBFF8, 32'd5);
        end
        rtc_i = 1'b0;

        // Byte enables and 64-bit wrap
        wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        wr(16'hBFF8, 32'h0, 4'hF);
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'b0011);
        rd(16'hBFF8, 32'h0000_FFFF);
        rd(16'hBFFC, 32'hFFFF_FFFF);
        wr(16'h4018, 32'h0, 4'hF);
        wr(16'h401C, 32'h0, 4'hF);
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        idle(2);
        check("irq_at_max", {60'd0, timer_irq_o}, 64'hF);
        wr(16'hBFF0, 32'h3, 4'hF);
        check("irq_wrap_g1", {60'd0, timer_irq_o}, 64'hF);
        rd(16'hBFF8, 32'hFFFF_FFFF);
        check("irq_wrap_g2", {60'd0, timer_irq_o}, 64'hF);
        rd(16'hBFFC, 32'h0);
        check("irq_wrap_g3", {60'd0, timer_irq_o}, 64'h8);
        rd(16'hBFF8, 32'h1);
        wr(16'hBFF0, 32'h0, 4'hF);
        idle(2);

        // Reset during a granted request: no response may follow
        req_i = 1'b1; we_i = 1'b0; addr_i = 16'hBFF0;
        #2;
        rst_i = 1'b1;
        @(posedge clk); #1;
        check("midrst_rvalid_a", {63'd0, rvalid_o}, 64'd0);
        req_i = 1'b0;
        @(posedge clk); #1;
        check("midrst_rvalid_b", {63'd0, rvalid_o}, 64'd0);
        rst_i = 1'b0;
        idle(1);
        check("midrst_rvalid_c", {63'd0, rvalid_o}, 64'd0);
        check("post_rst_ipi", {60'd0, ipi_o}, 64'h0);
        rd(16'hBFF0, 32'h1);
        rd(16'hBFF8, 32'h0);
        rd(16'h401C, 32'hFFFF_FFFF);
        idle(3);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
